// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock: N-way round-robin arbiter with registered one-hot grant
// and grant locking. An owner keeps the grant while its request stays high.
// On release the grant moves straight to the next requester in round-robin
// order, with no idle cycle between owners.
// Optional macro RR_ARB_MAX_HOLD_EN adds a hold limit of MAX_HOLD cycles.
// When the limit is reached and another request is pending, the arbiter
// forces a rotation and pulses preempt.
module rr_arbiter_lock #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           preempt
);

  if (N < 2 || N > 32) begin : g_bad_n
    $error("rr_arbiter_lock: N must be in 2..32");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
    $error("rr_arbiter_lock: MAX_HOLD must be in 2..256");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;

  // Index after i, wrapping at N. Handles N values that are not powers of 2.
  function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] i);
    return (i == IDW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  // First set bit of r, searching start, start+1, ... with modulo-N wrap.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0]   r,
                                             input logic [IDW-1:0] start);
    logic [N-1:0]   rot;
    logic [IDW-1:0] pick;
    logic           hit;
    int             pos;
    rot  = N'({r, r} >> start);
    pick = '0;
    hit  = 1'b0;
    pos  = 0;
    for (int k = 0; k < N; k++) begin
      if (!hit && rot[k]) begin
        hit = 1'b1;
        pos = int'(start) + k;
        if (pos >= N) pos = pos - N;
        pick = IDW'(pos);
      end
    end
    return pick;
  endfunction

  logic [N-1:0]   others;
  logic           own_req;
  logic [IDW-1:0] next_start;
  logic [IDW-1:0] idle_pick;
  logic [IDW-1:0] hand_pick;

  // The owner is excluded from the handoff search, so a releasing requester
  // that re-asserts at once still waits for its turn.
  assign others     = req & ~gnt;
  assign own_req    = |(req & gnt);
  assign next_start = inc_mod(gnt_id);
  assign idle_pick  = rr_pick(req, ptr);
  assign hand_pick  = rr_pick(others, next_start);

`ifdef RR_ARB_MAX_HOLD_EN
  localparam int HCW = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  logic [HCW-1:0] hold_cnt;
`endif

  logic           take;
  logic [IDW-1:0] take_id;
  logic           go_idle;
  logic           force_rot;

  // Next-owner decision: new grant, forced rotation, release to idle, or hold.
  always_comb begin
    take      = 1'b0;
    take_id   = '0;
    go_idle   = 1'b0;
    force_rot = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          take    = 1'b1;
          take_id = idle_pick;
        end
      end
      GRANT: begin
        if (own_req) begin
`ifdef RR_ARB_MAX_HOLD_EN
          if (hold_cnt == HOLD_LAST && |others) begin
            take      = 1'b1;
            take_id   = hand_pick;
            force_rot = 1'b1;
          end
`endif
        end else if (|others) begin
          take    = 1'b1;
          take_id = hand_pick;
        end else begin
          go_idle = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  // Arbiter FSM with registered grant outputs; ptr moves only on grant changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else if (take) begin
      state     <= GRANT;
      ptr       <= inc_mod(take_id);
      gnt       <= N'(1) << take_id;
      gnt_valid <= 1'b1;
      gnt_id    <= take_id;
    end else if (go_idle) begin
      state     <= IDLE;
      ptr       <= next_start;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end
  end

`ifdef RR_ARB_MAX_HOLD_EN
  // Hold counter for the current owner; it saturates while nobody else waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      preempt <= force_rot;
      if (take || go_idle) begin
        hold_cnt <= '0;
      end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: doc/rr_arbiter_lock.md
Name: rr_arbiter_lock

Overview:
Parametrised N-way round-robin arbiter with registered one-hot grant and grant locking. A granted requester keeps the grant until it drops its request; the grant then passes to the next requester in round-robin order with no idle bubble. It is intended for shared-resource access (bus, memory port, FIFO write side) where a requester needs multi-cycle ownership. An optional hold limit forces rotation so one requester cannot starve the others.

Parameters:
N, 4, number of requesters; legal range 2..32.
MAX_HOLD, 16, maximum consecutive grant cycles per owner. Used only when RR_ARB_MAX_HOLD_EN is defined; legal range 2..256.
IDW, $clog2(N), width of gnt_id. Derived; not overridden.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req  input  N  request vector; bit i asserted = requester i wants or keeps ownership
gnt  output  N  registered one-hot grant; all-zero = no owner
gnt_valid  output  1  registered; equals |gnt
gnt_id  output  IDW  registered binary index of the owner; 0 when gnt_valid=0
preempt  output  1  registered one-cycle pulse on a forced rotation; tied 0 without the macro

Behaviour:
- Reset: clk is the clock; rst_n is an asynchronous, active-low reset.
  - While reset is asserted: gnt=0, gnt_valid=0, gnt_id=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0.
- ptr (IDW bits) is the index where the search starts. The search order is ptr, ptr+1, …, N-1, 0, …, ptr-1, with modulo-N wrap. This is correct for non-power-of-2 N.
- All outputs are registered. A decision made from req in cycle t is visible in cycle t+1 (latency 1).
- State IDLE (gnt=0):
  - If any req bit is set, grant the first set bit in search order from ptr and go to GRANT.
  - If no req bit is set, stay in IDLE.
- State GRANT (owner o):
  - If req[o]=1: keep the grant. No change, except under the hold limit described below.
  - If req[o]=0 (release): set ptr=o+1 mod N. Search req with bit o masked, starting from o+1.
    - If a requester is found, grant it in the next cycle. This is a direct owner-to-owner handoff with no zero cycle.
    - If none is found, set gnt=0 and go to IDLE.
- Simultaneous events:
  - A new request arriving on the same cycle as a release takes part in that cycle's search.
  - The releasing requester is excluded from that search even if it re-asserts req the next cycle. It waits its turn.
- ptr updates only on a grant change:
  - When a new owner o' is granted, ptr = o'+1 mod N.
  - After reset, the first search starts at index 0.
- gnt is always one-hot or zero; no other encoding is reachable. gnt_id always matches gnt.
- If rst_n is asserted mid-grant, all state clears at once. The first grant after reset starts the search from index 0.
- req bits are sampled synchronously. No glitch filtering is done; callers drive req from flops.

Optional Feature:
RR_ARB_MAX_HOLD_EN
- Defined:
  - hold_cnt counts the cycles the current owner has held the grant. It clears to 0 on every grant change.
  - When hold_cnt = MAX_HOLD-1, req[o]=1 and another req bit is set: force a rotation to the next requester after o, set ptr=o+1, and pulse preempt=1 for one cycle together with the new gnt.
  - If no other requester is pending, the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1. A rotation then occurs on the first cycle another request appears.
- Not defined:
  - No hold_cnt logic. Ownership is unlimited and preempt is constant 0.

Test Plan:
1. N=4, req=0001 held → gnt=0001, gnt_id=0 from the cycle after req rises. Drop req → gnt=0000 the next cycle, state IDLE, ptr=1.
2. N=4, all req pulsed one cycle each on release (1111, each owner drops after 2 cycles) → grant order 0,1,2,3,0 with no zero cycles between owners.
3. N=4: owner 2 releases in the same cycle req[0] and req[3] rise → next owner 3. After 3 releases, owner 0.
4. N=5 (non-power-of-2): owner 4 releases with req=00011 → next owner 0 (wrap). gnt_id=0, no out-of-range index.
5. Assert rst_n=0 mid-grant with owner 2 → outputs all 0 immediately. After release, req=1111 → first gnt=0001.
6. RR_ARB_MAX_HOLD_EN, MAX_HOLD=4, req=0011 held constantly → owner 0 for 4 cycles, then owner 1 with preempt=1 for one cycle, then owner 0 after 4 more cycles. With req=0001 only → owner 0 is held indefinitely and preempt stays 0.
